// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and instruction-fetch stage. Keeps the architectural PC,
//   issues one instruction-memory request at a time over req/gnt/rvalid,
//   presents the fetched instruction to decode, and forms the next PC when
//   that instruction retires. A misaligned branch/jump target redirects to
//   TRAP_VEC and raises a one-cycle misalign_trap pulse.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   pc_src, target    : branch decision and target for the presented instr
//   stall             : hold the presented instruction (blocks retire)
//   instr_ready       : decode/execute consumes the presented instruction
//   imem_req/addr     : fetch request and word-aligned fetch address
//   imem_gnt          : memory accepted the request
//   imem_rvalid/rdata : read response
//   instr, pc         : presented instruction and its address
//   instr_valid       : instr/pc are valid
//   misalign_trap     : one-cycle pulse on a misaligned redirect
//   instret           : retired-instruction counter
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic [31:0] target,
  input  logic        stall,
  input  logic        instr_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        misalign_trap,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RST,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nxt;
  logic        retire;
  logic        redirect_trap;

  assign retire = (state == ST_HOLD) && instr_ready && !stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:  state_nxt = ST_REQ;
      ST_REQ:  if (imem_gnt)    state_nxt = ST_WAIT;
      ST_WAIT: if (imem_rvalid) state_nxt = ST_HOLD;
      ST_HOLD: if (retire)      state_nxt = ST_REQ;
      default: state_nxt = ST_RST;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_REQ:  imem_req    = 1'b1;
      ST_HOLD: instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Next fetch address. A set target[1] means the target is not 4-byte
  // aligned; target[0] is dropped as JALR does.
  always_comb begin
    redirect_trap = 1'b0;
    fetch_pc_nxt  = pc + 32'd4;
    if (pc_src) begin
      if (target[1]) begin
        redirect_trap = 1'b1;
        fetch_pc_nxt  = TRAP_VEC;
      end else begin
        fetch_pc_nxt  = target & 32'hFFFF_FFFC;
      end
    end
  end

  // fetch_pc only changes on retire, so imem_addr is stable throughout REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc      <= RESET_PC;
      instr         <= NOP;
      pc            <= RESET_PC;
      misalign_trap <= 1'b0;
      instret       <= '0;
    end else begin
      misalign_trap <= 1'b0;
      if (state == ST_WAIT && imem_rvalid) begin
        instr <= imem_rdata;
        pc    <= fetch_pc;
      end
      if (retire) begin
        fetch_pc      <= fetch_pc_nxt;
        misalign_trap <= redirect_trap;
        instret       <= instret + 32'd1;
      end
    end
  end

  assign imem_addr = fetch_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] target = '0;
  logic        stall = 1'b0;
  logic        instr_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        misalign_trap;
  logic [31:0] instret;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .target(target),
    .stall(stall), .instr_ready(instr_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .misalign_trap(misalign_trap), .instret(instret)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model state: address of the next expected fetch and the
  // expected number of retired instructions.
  logic [31:0] exp_addr;
  logic [31:0] exp_instret;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pc_src = 1'b0; target = '0; stall = 1'b0; instr_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passes++;
    checks++; if (imem_addr !== RESET_PC) $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); else passes++;
    checks++; if (instr !== NOP) $display("FAIL rst_instr: got %h want %h", instr, NOP); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else passes++;
    checks++; if (pc !== RESET_PC) $display("FAIL rst_pc: got %h want %h", pc, RESET_PC); else passes++;
    checks++; if (misalign_trap !== 1'b0) $display("FAIL rst_trap: got %b want 0", misalign_trap); else passes++;
    checks++; if (instret !== 32'd0) $display("FAIL rst_instret: got %0d want 0", instret); else passes++;
    rst_n = 1'b1;
    exp_addr    = RESET_PC;
    exp_instret = '0;
  endtask

  // One full fetch/retire transaction: gd cycles without gnt, rd cycles
  // without rvalid, sd cycles holding without retire, then a retire with
  // the given branch decision. noise drives rvalid/gnt where they must be
  // ignored.
  task automatic txn(input int unsigned gd, input int unsigned rd,
                     input int unsigned sd, input logic take,
                     input logic [31:0] tgt, input logic [31:0] data,
                     input logic noise);
    int unsigned n = 0;
    logic exp_trap;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (imem_req !== 1'b1) $display("FAIL req_timeout: got %b want 1 after %0d cycles", imem_req, n); else passes++;
    checks++; if (imem_addr !== exp_addr) $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_addr); else passes++;
    imem_rvalid = noise;
    imem_rdata  = ~data;
    for (int unsigned i = 0; i < gd; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr)
        $display("FAIL addr_hold: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp_addr); else passes++;
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b0 || misalign_trap !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL wait_state: got req=%b trap=%b valid=%b want 0/0/0", imem_req, misalign_trap, instr_valid); else passes++;
    for (int unsigned i = 0; i < rd; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0)
        $display("FAIL wait_hold: got valid=%b req=%b want 0/0", instr_valid, imem_req); else passes++;
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = noise;
    imem_rdata  = ~data;
    imem_gnt    = noise;
    checks++; if (instr !== data || pc !== exp_addr || instr_valid !== 1'b1)
      $display("FAIL present: got instr=%h pc=%h valid=%b want %h/%h/1", instr, pc, instr_valid, data, exp_addr); else passes++;
    for (int unsigned i = 0; i < sd; i++) begin
      stall       = (noise ? 1'($urandom_range(0, 1)) : 1'b1);
      instr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!noise) instr_ready = 1'b1;
      pc_src = 1'b1;
      target = $urandom;
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== data || pc !== exp_addr || instret !== exp_instret || imem_req !== 1'b0)
        $display("FAIL stall_hold: got valid=%b instr=%h pc=%h instret=%0d req=%b want 1/%h/%h/%0d/0",
                 instr_valid, instr, pc, instret, imem_req, data, exp_addr, exp_instret); else passes++;
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    stall = 1'b0; instr_ready = 1'b1; pc_src = take; target = tgt;
    tick();
    idle_inputs();
    exp_trap = take && tgt[1];
    if (!take)       exp_addr = exp_addr + 32'd4;
    else if (tgt[1]) exp_addr = TRAP_VEC;
    else             exp_addr = {tgt[31:2], 2'b00};
    exp_instret = exp_instret + 32'd1;
    checks++; if (instret !== exp_instret) $display("FAIL instret: got %0d want %0d", instret, exp_instret); else passes++;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL after_retire: got valid=%b req=%b want 0/1", instr_valid, imem_req); else passes++;
    checks++; if (misalign_trap !== exp_trap) $display("FAIL trap_pulse: got %b want %b", misalign_trap, exp_trap); else passes++;
  endtask

  task automatic test_reset;
    apply_reset();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); else passes++;
    txn(0, 0, 0, 1'b0, '0, 32'h0050_0093, 1'b0);
    checks++; if (imem_addr !== 32'h4 || instret !== 32'd1)
      $display("FAIL first_next: got addr=%h instret=%0d want 4/1", imem_addr, instret); else passes++;
  endtask

  task automatic test_sequential;
    apply_reset();
    for (int i = 0; i < 4; i++) txn(0, 0, 0, 1'b0, '0, 32'h1000_0000 + 32'(i), 1'b0);
    checks++; if (instret !== 32'd4 || imem_addr !== 32'h10)
      $display("FAIL seq_end: got instret=%0d addr=%h want 4/10", instret, imem_addr); else passes++;
  endtask

  task automatic test_branch;
    apply_reset();
    txn(0, 0, 0, 1'b0, '0, 32'h11, 1'b0);
    txn(0, 0, 0, 1'b0, '0, 32'h22, 1'b0);
    txn(0, 0, 0, 1'b1, 32'h40, 32'h33, 1'b0);
    checks++; if (imem_addr !== 32'h40) $display("FAIL branch_addr: got %h want 40", imem_addr); else passes++;
    txn(0, 0, 0, 1'b1, 32'h81, 32'h44, 1'b0);
    checks++; if (imem_addr !== 32'h80 || misalign_trap !== 1'b0)
      $display("FAIL jalr_addr: got addr=%h trap=%b want 80/0", imem_addr, misalign_trap); else passes++;
  endtask

  task automatic test_trap;
    txn(0, 0, 0, 1'b1, 32'h22, 32'h55, 1'b0);
    checks++; if (imem_addr !== TRAP_VEC || misalign_trap !== 1'b1)
      $display("FAIL trap_redirect: got addr=%h trap=%b want %h/1", imem_addr, misalign_trap, TRAP_VEC); else passes++;
    txn(0, 0, 0, 1'b0, '0, 32'h66, 1'b0);
  endtask

  task automatic test_delays_stall;
    txn(3, 2, 4, 1'b0, '0, 32'hCAFE_0001, 1'b0);
    txn(1, 3, 2, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_0002, 1'b0);
    txn(0, 1, 0, 1'b0, '0, 32'hCAFE_0003, 1'b0);
    checks++; if (imem_addr !== 32'h0) $display("FAIL pc_wrap: got %h want 0", imem_addr); else passes++;
  endtask

  task automatic test_reset_in_wait;
    apply_reset();
    for (int i = 0; i < 4; i++) txn(0, 0, 0, 1'b0, '0, 32'h2000_0000 + 32'(i), 1'b0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL pre_wait: got req=%b addr=%h want 1/10", imem_req, imem_addr); else passes++;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instret !== 32'd0 || instr !== NOP || pc !== RESET_PC)
      $display("FAIL async_rst: got req=%b addr=%h instret=%0d instr=%h pc=%h", imem_req, imem_addr, instret, instr, pc); else passes++;
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL late_rvalid: got valid=%b instr=%h req=%b addr=%h want 0/%h/1/%h",
               instr_valid, instr, imem_req, imem_addr, NOP, RESET_PC); else passes++;
    exp_addr    = RESET_PC;
    exp_instret = '0;
    txn(0, 0, 0, 1'b0, '0, 32'h3000_0000, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] tgt;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt[1] = 1'b0;
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), tgt, $urandom, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_trap();
    test_delays_stall();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the RISC-V core. Holds the architectural PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It presents the fetched instruction to decode and, when that instruction retires, takes the branch decision (`pc_src`) and `target` from the branch/jump path to form the next PC. It also flags misaligned control-flow targets and redirects them to a trap vector.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `TRAP_VEC`, 32'h0000_0100: redirect address on a misaligned branch/jump target.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc_src`  in  1: take branch/jump for the instruction currently presented.
- `target`  in  32: branch/jump target for that instruction.
- `stall`  in  1: hold the current instruction; blocks retire.
- `instr_ready`  in  1: decode/execute consumes the presented instruction.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, word aligned.
- `imem_gnt`  in  1: memory accepts the request this cycle.
- `imem_rvalid`  in  1: read data valid.
- `imem_rdata`  in  32: read data.
- `instr`  out  32: registered instruction.
- `instr_valid`  out  1: `instr`/`pc` are valid.
- `pc`  out  32: address of `instr`.
- `misalign_trap`  out  1: one-cycle pulse on a misaligned redirect.
- `instret`  out  32: retired-instruction counter.

## Operation
- FSM states: RST, REQ, WAIT, HOLD.
  - RST → REQ on the first clock edge after `rst_n` is high.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`. When `imem_gnt`=1, go to WAIT.
  - WAIT: `imem_req`=0. When `imem_rvalid`=1, set `instr`←`imem_rdata`, `pc`←`fetch_pc`, `instr_valid`←1, and go to HOLD.
  - HOLD: `instr_valid`=1. Retire condition is `retire = instr_ready & ~stall`. On retire, go to REQ and clear `instr_valid`.
- Next PC, evaluated only on retire:
  - `pc_src`=0: `fetch_pc`←`pc`+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
  - `pc_src`=1, `target[1]`=0: `fetch_pc`←{`target[31:2]`,2'b00}. Bit 0 is always cleared, per JALR semantics.
  - `pc_src`=1, `target[1]`=1: `fetch_pc`←`TRAP_VEC`, `misalign_trap`←1 for exactly one cycle.
- `pc_src` and `target` are ignored outside a retire cycle.
- `instret` increments by 1 on each retire and wraps at 2^32. A trap-causing instruction still counts as retired.
- `imem_rvalid` outside WAIT is ignored.
- `imem_gnt` outside REQ is ignored.
- Only one request is outstanding at a time.
- `stall`=1 with `instr_ready`=1: the instruction is held, with no PC update and no counter increment.

## Timing
- Reset values:
  - state RST
  - `imem_req` 0, `imem_addr` `RESET_PC`
  - `instr` 32'h0000_0013 (NOP), `instr_valid` 0, `pc` `RESET_PC`
  - `misalign_trap` 0, `instret` 0
  - internal `fetch_pc` `RESET_PC`
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- `imem_addr` is stable for the whole time `imem_req`=1.
- Best-case fetch:
  - cycle N: REQ with `gnt`.
  - cycle N+1: WAIT with `rvalid`.
  - cycle N+2: HOLD, `instr_valid`=1.
  - Retire in N+2 puts REQ in N+3, giving 3 cycles per instruction.
- Each extra cycle without `gnt` or without `rvalid` adds one cycle.
- `misalign_trap` is high during the first REQ cycle following the offending retire.
- Asynchronous reset in any state, including WAIT with a request outstanding, returns immediately to reset values.
  - A late `rvalid` arriving after reset is dropped, because the FSM is not in WAIT.
  - The first post-reset fetch goes to `RESET_PC`.

## Test plan
- Reset release, memory grants immediately with `rvalid` next cycle, `imem_rdata`=0x00500093, `instr_ready`=1 → `imem_addr`=0x0 in the first REQ; `instr`=0x00500093, `pc`=0, `instr_valid`=1 two cycles later; next request at 0x4; `instret`=1.
- Sequential fetch of 4 instructions with `pc_src`=0 → `imem_addr` sequence 0x0, 0x4, 0x8, 0xC; `instret`=4.
- Taken branch at pc=0x8 with `pc_src`=1, `target`=0x40 → next `imem_addr`=0x40. JALR-style `target`=0x81 → next `imem_addr`=0x80, `misalign_trap` stays 0.
- `pc_src`=1, `target`=0x22 → `misalign_trap` pulses for 1 cycle, next `imem_addr`=0x100, `instret` increments.
- `gnt` delayed 3 cycles and `rvalid` delayed 2 cycles; `stall`=1 for 4 cycles while in HOLD → `imem_addr` held; `instr` and `pc` held; no retire until `stall` drops.
- `rst_n` asserted in WAIT at PC 0x10, `rvalid` arrives the cycle after release → the data is ignored, `instr_valid`=0, and the next request goes to 0x0.
